// File: rtl/me_stream_feeder_pkg.sv
// rtl/me_stream_feeder_pkg.sv - block geometry and sequencer state encodings shared with the PE row
package me_stream_feeder_pkg;

   localparam int BLK_SIZE     = 4;
   localparam int BS_SQ        = BLK_SIZE * BLK_SIZE;
   localparam int N            = BLK_SIZE * (BS_SQ + 1);
   localparam int DRAIN_CYCLES = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_DRAIN,
      ST_WAIT_DONE,
      ST_REPORT
   } st_e;

   function automatic int cw(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/me_stream_feeder_if.sv
// rtl/me_stream_feeder_if.sv - job, frame-buffer read and PE-row signals of the stream feeder
interface me_stream_feeder_if #(
   parameter int AW = 16
);
   logic          go;
   logic [AW-1:0] cur_base;
   logic [AW-1:0] sw_base;
   logic          busy;
   logic          cur_rd;
   logic [AW-1:0] cur_addr;
   logic [7:0]    cur_data;
   logic          swa_rd;
   logic [AW-1:0] swa_addr;
   logic [7:0]    swa_data;
   logic          swb_rd;
   logic [AW-1:0] swb_addr;
   logic [7:0]    swb_data;
   logic [7:0]    c;
   logic [7:0]    p;
   logic [7:0]    p_prime;
   logic          pe_start;
   logic          pe_done;
   logic [7:0]    pe_mi;
   logic [7:0]    pe_mj;
   logic          mv_valid;
   logic [7:0]    mv_i;
   logic [7:0]    mv_j;
   logic          mv_err;

   modport master (
      input  go, cur_base, sw_base, cur_data, swa_data, swb_data, pe_done, pe_mi, pe_mj,
      output busy, cur_rd, cur_addr, swa_rd, swa_addr, swb_rd, swb_addr,
             c, p, p_prime, pe_start, mv_valid, mv_i, mv_j, mv_err
   );

   modport slave (
      output go, cur_base, sw_base, cur_data, swa_data, swb_data, pe_done, pe_mi, pe_mj,
      input  busy, cur_rd, cur_addr, swa_rd, swa_addr, swb_rd, swb_addr,
             c, p, p_prime, pe_start, mv_valid, mv_i, mv_j, mv_err
   );

endinterface

// File: rtl/me_addr_gen.sv
// rtl/me_addr_gen.sv - beat counters and stride accumulator producing the three read addresses
module me_addr_gen
   import me_stream_feeder_pkg::*;
#(
   parameter int AW        = 16,
   parameter int SW_STRIDE = 16,
   parameter int SW_ROWS   = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load_i,
   input  logic          adv_i,
   input  logic [AW-1:0] cur_base_i,
   input  logic [AW-1:0] sw_base_i,
   output logic [AW-1:0] cur_addr_o,
   output logic [AW-1:0] swa_addr_o,
   output logic [AW-1:0] swb_addr_o,
   output logic          last_beat_o
);
   localparam int TW = cw(N);
   localparam int JW = cw(BLK_SIZE);
   localparam int RW = cw(SW_ROWS);
   localparam int OW = cw(BS_SQ);

   localparam logic [TW-1:0] T_LAST = TW'(N - 1);
   localparam logic [JW-1:0] J_LAST = JW'(BLK_SIZE - 1);
   localparam logic [RW-1:0] R_LAST = RW'(SW_ROWS - 1);
   localparam logic [OW-1:0] O_LAST = OW'(BS_SQ - 1);

   logic [AW-1:0] cur_base_q, sw_base_q, row_off_q;
   logic [TW-1:0] t_q;
   logic [JW-1:0] j_q;
   logic [RW-1:0] r_q;
   logic [OW-1:0] co_q;

   // row_off_q tracks r*SW_STRIDE so no multiplier is needed
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cur_base_q <= '0;
         sw_base_q  <= '0;
         row_off_q  <= '0;
         t_q        <= '0;
         j_q        <= '0;
         r_q        <= '0;
         co_q       <= '0;
      end else if (load_i) begin
         cur_base_q <= cur_base_i;
         sw_base_q  <= sw_base_i;
         row_off_q  <= '0;
         t_q        <= '0;
         j_q        <= '0;
         r_q        <= '0;
         co_q       <= '0;
      end else if (adv_i) begin
         t_q  <= t_q + 1'b1;
         co_q <= (co_q == O_LAST) ? '0 : co_q + 1'b1;
         if (j_q == J_LAST) begin
            j_q <= '0;
            if (r_q == R_LAST) begin
               r_q       <= '0;
               row_off_q <= '0;
            end else begin
               r_q       <= r_q + 1'b1;
               row_off_q <= row_off_q + AW'(SW_STRIDE);
            end
         end else begin
            j_q <= j_q + 1'b1;
         end
      end
   end

   assign swa_addr_o  = sw_base_q + row_off_q + AW'(j_q);
   assign swb_addr_o  = swa_addr_o + AW'(BLK_SIZE);
   assign cur_addr_o  = cur_base_q + AW'(co_q);
   assign last_beat_o = (t_q == T_LAST);

endmodule

// File: rtl/me_stream_feeder.sv
// rtl/me_stream_feeder.sv - sequences one PE-row job: streams block/window pixels, then collects the motion vector
module me_stream_feeder
   import me_stream_feeder_pkg::*;
#(
   parameter int AW        = 16,
   parameter int SW_STRIDE = 16,
   parameter int SW_ROWS   = 8,
   parameter int TIMEOUT   = 64
) (
   input  logic clk,
   input  logic reset,
   me_stream_feeder_if.master bus
);
   localparam int CW = cw(TIMEOUT);
   localparam logic [CW-1:0] CNT_EXPIRE = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_CYCLES - 1);

   st_e           state_q;
   logic [CW-1:0] cnt_q;
   logic          issue_q, vld_q, start_q;
   logic          busy_q, pe_start_q, mv_valid_q, mv_err_q;
   logic [7:0]    c_q, p_q, pp_q, mv_i_q, mv_j_q;
   logic          load, last_beat;
   logic [AW-1:0] cur_addr, swa_addr, swb_addr;

   assign load = (state_q == ST_IDLE) && bus.go;

   me_addr_gen #(
      .AW        (AW),
      .SW_STRIDE (SW_STRIDE),
      .SW_ROWS   (SW_ROWS)
   ) u_addr_gen (
      .clk         (clk),
      .reset       (reset),
      .load_i      (load),
      .adv_i       (issue_q),
      .cur_base_i  (bus.cur_base),
      .sw_base_i   (bus.sw_base),
      .cur_addr_o  (cur_addr),
      .swa_addr_o  (swa_addr),
      .swb_addr_o  (swb_addr),
      .last_beat_o (last_beat)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         issue_q    <= 1'b0;
         busy_q     <= 1'b0;
         mv_valid_q <= 1'b0;
         mv_err_q   <= 1'b0;
         mv_i_q     <= '0;
         mv_j_q     <= '0;
      end else begin
         mv_valid_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (bus.go) begin
                  state_q <= ST_ISSUE;
                  busy_q  <= 1'b1;
                  issue_q <= 1'b1;
               end
            end
            ST_ISSUE: begin
               if (last_beat) begin
                  state_q <= ST_DRAIN;
                  issue_q <= 1'b0;
                  cnt_q   <= '0;
               end
            end
            ST_DRAIN: begin
               if (cnt_q == DRAIN_LAST) begin
                  state_q <= ST_WAIT_DONE;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            ST_WAIT_DONE: begin
               // pe_done wins over a watchdog expiry in the same cycle
               if (bus.pe_done) begin
                  state_q    <= ST_REPORT;
                  mv_valid_q <= 1'b1;
                  mv_err_q   <= 1'b0;
                  mv_i_q     <= bus.pe_mi;
                  mv_j_q     <= bus.pe_mj;
               end else if (cnt_q == CNT_EXPIRE) begin
                  state_q    <= ST_REPORT;
                  mv_valid_q <= 1'b1;
                  mv_err_q   <= 1'b1;
                  mv_i_q     <= '0;
                  mv_j_q     <= '0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            ST_REPORT: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // memory returns beat data one cycle after issue; the output register adds the second cycle of lag
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vld_q      <= 1'b0;
         start_q    <= 1'b0;
         pe_start_q <= 1'b0;
         c_q        <= '0;
         p_q        <= '0;
         pp_q       <= '0;
      end else begin
         vld_q      <= issue_q;
         start_q    <= issue_q & ~vld_q;
         pe_start_q <= start_q;
         c_q        <= vld_q ? bus.cur_data : 8'h00;
         p_q        <= vld_q ? bus.swb_data : 8'h00;
         pp_q       <= vld_q ? bus.swa_data : 8'h00;
      end
   end

   assign bus.busy     = busy_q;
   assign bus.cur_rd   = issue_q;
   assign bus.swa_rd   = issue_q;
   assign bus.swb_rd   = issue_q;
   assign bus.cur_addr = issue_q ? cur_addr : '0;
   assign bus.swa_addr = issue_q ? swa_addr : '0;
   assign bus.swb_addr = issue_q ? swb_addr : '0;
   assign bus.c        = c_q;
   assign bus.p        = p_q;
   assign bus.p_prime  = pp_q;
   assign bus.pe_start = pe_start_q;
   assign bus.mv_valid = mv_valid_q;
   assign bus.mv_i     = mv_i_q;
   assign bus.mv_j     = mv_j_q;
   assign bus.mv_err   = mv_err_q;

endmodule

// File: tb/tb_me_stream_feeder.sv
// tb/tb_me_stream_feeder.sv - directed bench for me_stream_feeder with synchronous SRAM models
module tb_me_stream_feeder;
   import me_stream_feeder_pkg::*;

   logic clk = 1'b0;
   logic reset;
   int   n_chk  = 0;
   int   n_pass = 0;

   me_stream_feeder_if #(.AW(16)) bus ();

   me_stream_feeder #(
      .AW        (16),
      .SW_STRIDE (16),
      .SW_ROWS   (8),
      .TIMEOUT   (64)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] cur_pat(input logic [15:0] a);
      return a[7:0] ^ 8'h5A ^ {a[11:8], 4'h0};
   endfunction

   function automatic logic [7:0] sw_pat(input logic [15:0] a);
      return 8'(a[7:0] * 8'd7) ^ a[15:8];
   endfunction

   always @(posedge clk) begin
      bus.cur_data <= bus.cur_rd ? cur_pat(bus.cur_addr) : 8'h00;
      bus.swa_data <= bus.swa_rd ? sw_pat(bus.swa_addr) : 8'h00;
      bus.swb_data <= bus.swb_rd ? sw_pat(bus.swb_addr) : 8'h00;
   end

   function automatic logic [15:0] exp_swa(input logic [15:0] sb, input int t);
      int g, j, r;
      g = t / BLK_SIZE;
      j = t % BLK_SIZE;
      r = g % 8;
      return 16'(int'(sb) + r * 16 + j);
   endfunction

   function automatic logic [15:0] exp_cur(input logic [15:0] cb, input int t);
      return 16'(int'(cb) + t % BS_SQ);
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic run_job(input logic [15:0] cb, input logic [15:0] sb, input int done_at,
                          input logic [7:0] mi, input logic [7:0] mj, input bit poke);
      int          rep;
      bit          ok;
      logic [15:0] a;
      ok  = (done_at >= 0) && (done_at < 64);
      rep = ok ? done_at + 1 : 64;
      bus.cur_base = cb;
      bus.sw_base  = sb;
      bus.go       = 1'b1;
      @(negedge clk);
      bus.go = 1'b0;
      for (int k = 1; k <= N + 2; k++) begin
         if (k <= N) begin
            a = exp_swa(sb, k - 1);
            chk($sformatf("rd k=%0d", k), 32'({bus.cur_rd, bus.swa_rd, bus.swb_rd}), 32'h7);
            chk($sformatf("cur_addr k=%0d", k), 32'(bus.cur_addr), 32'(exp_cur(cb, k - 1)));
            chk($sformatf("swa_addr k=%0d", k), 32'(bus.swa_addr), 32'(a));
            chk($sformatf("swb_addr k=%0d", k), 32'(bus.swb_addr), 32'(16'(a + 16'd4)));
         end else begin
            chk($sformatf("rd off k=%0d", k), 32'({bus.cur_rd, bus.swa_rd, bus.swb_rd}), 32'h0);
         end
         chk($sformatf("pe_start k=%0d", k), 32'(bus.pe_start), 32'(k == 3));
         if (k >= 3) begin
            a = exp_swa(sb, k - 3);
            chk($sformatf("c k=%0d", k), 32'(bus.c), 32'(cur_pat(exp_cur(cb, k - 3))));
            chk($sformatf("p k=%0d", k), 32'(bus.p), 32'(sw_pat(16'(a + 16'd4))));
            chk($sformatf("p_prime k=%0d", k), 32'(bus.p_prime), 32'(sw_pat(a)));
         end
         chk($sformatf("busy k=%0d", k), 32'(bus.busy), 32'h1);
         bus.go      = poke && (k == 10);
         bus.pe_done = poke && (k == 20);
         bus.pe_mi   = 8'h77;
         bus.pe_mj   = 8'h66;
         @(negedge clk);
      end
      chk("c after drain", 32'(bus.c), 32'h0);
      chk("p_prime after drain", 32'(bus.p_prime), 32'h0);
      for (int w = 0; w <= rep; w++) begin
         chk($sformatf("mv_valid w=%0d", w), 32'(bus.mv_valid), 32'(w == rep));
         if (w == rep) begin
            chk("mv_err", 32'(bus.mv_err), 32'(!ok));
            chk("mv_i", 32'(bus.mv_i), ok ? 32'(mi) : 32'h0);
            chk("mv_j", 32'(bus.mv_j), ok ? 32'(mj) : 32'h0);
            chk("busy in report", 32'(bus.busy), 32'h1);
         end
         bus.pe_done = (w == done_at);
         bus.pe_mi   = mi;
         bus.pe_mj   = mj;
         @(negedge clk);
      end
      bus.pe_done = 1'b0;
      chk("busy after report", 32'(bus.busy), 32'h0);
      chk("mv_valid pulse end", 32'(bus.mv_valid), 32'h0);
      chk("mv_i hold", 32'(bus.mv_i), ok ? 32'(mi) : 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset        = 1'b0;
      bus.go       = 1'b0;
      bus.cur_base = '0;
      bus.sw_base  = '0;
      bus.pe_done  = 1'b0;
      bus.pe_mi    = '0;
      bus.pe_mj    = '0;
      repeat (2) @(negedge clk);
      chk("reset busy", 32'(bus.busy), 32'h0);
      chk("reset rd", 32'({bus.cur_rd, bus.swa_rd, bus.swb_rd}), 32'h0);
      chk("reset swb_addr", 32'(bus.swb_addr), 32'h0);
      chk("reset c", 32'(bus.c), 32'h0);
      chk("reset mv", 32'({bus.mv_valid, bus.mv_err, bus.mv_i, bus.mv_j}), 32'h0);
      reset = 1'b1;
      @(negedge clk);
      chk("idle busy", 32'(bus.busy), 32'h0);

      run_job(16'h0100, 16'h0000, 5, 8'hFE, 8'h01, 1'b0);
      run_job(16'h0200, 16'hFFFE, -1, 8'hAA, 8'h55, 1'b0);
      run_job(16'h0300, 16'h1230, 63, 8'h12, 8'h34, 1'b1);

      bus.cur_base = 16'h0100;
      bus.sw_base  = 16'h0040;
      bus.go       = 1'b1;
      @(negedge clk);
      bus.go = 1'b0;
      repeat (20) @(negedge clk);
      chk("beat 20 swa_addr", 32'(bus.swa_addr), 32'(exp_swa(16'h0040, 20)));
      #1 reset = 1'b0;
      #1;
      chk("async rst busy", 32'(bus.busy), 32'h0);
      chk("async rst rd", 32'({bus.cur_rd, bus.swa_rd, bus.swb_rd}), 32'h0);
      chk("async rst addr", 32'({bus.cur_addr, bus.swa_addr}), 32'h0);
      chk("async rst swb_addr", 32'(bus.swb_addr), 32'h0);
      chk("async rst pix", 32'({bus.c, bus.p, bus.p_prime}), 32'h0);
      chk("async rst mv", 32'({bus.mv_valid, bus.pe_start}), 32'h0);
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         chk($sformatf("post rst quiet %0d", i), 32'({bus.mv_valid, bus.busy}), 32'h0);
      end
      run_job(16'h0100, 16'h0040, 0, 8'h3C, 8'hC3, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
